ring_out_arbiter: RTL and testbench
===================================

Name: ring_out_arbiter

Overview:
- Output-port arbiter for one ring direction (cw or ccw) of the router.
- Shares the port's two single-slot virtual-channel output buffers (even and odd) between two requesters: the same-direction ring input and the PE input.
- Grants one requester per VC per internal phase and captures its packet.
- Drains each buffer to the next router with the so/ro handshake during that VC's external phase.

Parameters:
- DATA_WIDTH, 64, packet width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- polarity  input  1  phase bit, toggles every cycle. polarity=1 makes the odd VC internal and the even VC external; polarity=0 is the reverse.
- req_ring_even, req_ring_odd  input  1 each  ring-input request per VC.
- req_pe_even, req_pe_odd  input  1 each  PE-input request per VC.
- data_ring_even, data_ring_odd  input  DATA_WIDTH each  ring-input packet per VC.
- data_pe_even, data_pe_odd  input  DATA_WIDTH each  PE-input packet per VC.
- grant_ring_even, grant_ring_odd, grant_pe_even, grant_pe_odd  output  1 each  combinational grant.
- ro  input  1  downstream ready for the VC currently in its external phase.
- so  output  1  send-out valid.
- dout  output  DATA_WIDTH  outgoing packet.

Behaviour:
- State per VC v in {even, odd}:
  - buf_v (DATA_WIDTH)
  - full_v (1 bit)
  - rr_v (1 bit): 0 = ring preferred, 1 = PE preferred
- Reset: buf_v=0, full_v=0, rr_v=0. While rst=1, all grants=0, so=0, dout=0.
- Internal VC: vi = odd if polarity else even. External VC: ve = the other VC.
- Grants:
  - Only VC vi may grant, and only when full_vi=0. The VC ve never grants in that cycle.
  - If exactly one requester of vi is asserting, it is granted.
  - If both are asserting, the preferred one per rr_vi is granted.
  - At most one grant is high at any time. Grants depend purely on current inputs and state, so a requester that withdraws is not granted.
- Capture, at the posedge of a granting cycle:
  - buf_vi <= winner's data; full_vi <= 1.
  - rr_vi <= 1 if ring won, 0 if PE won. rr changes only on a grant.
  - No header modification; hop and direction fields pass through unchanged.
- Send:
  - so = full_ve & ro; dout = so ? buf_ve : 0.
  - At the posedge of a cycle with so=1, full_ve <= 0.
  - If ro=0, the buffer holds and is retried on that VC's next external phase.
- Fill and drain of one VC never occur in the same cycle (opposite phases).
- Full buffer: requests are left pending with no grant. The requester holds its request and data.
- Latency:
  - grant in cycle N, capture at the end of N;
  - earliest send in cycle N+1 (next phase, same VC now external);
  - buffer free for a new grant in cycle N+2.
  - Sustained throughput: one packet per VC per 2 cycles.
- Reset mid-operation: buffered packets are discarded, full flags cleared, rr returns to ring-preferred. Still-asserted requests are granted from the first internal phase after rst deasserts.
- polarity is sampled combinationally every cycle. No assumption of alternation beyond vi/ve selection; if polarity holds steady, one VC fills and the other drains repeatedly.

Optional Feature:
- Macro: RING_PRIORITY_EN.
- Defined: fixed priority. The ring request always wins over PE on contention (in-flight traffic first); rr_v is not implemented or updated.
- Undefined: round-robin per VC as above.

Test Plan:
- Reset, then polarity=1, req_pe_odd=1 with data_pe_odd=64'h4000_0000_0000_00AA, ro=1 → grant_pe_odd=1 that cycle. Next cycle (polarity=0): so=1, dout=64'h4000_0000_0000_00AA. full_odd cleared after.
- Both odd requesters held high, ro=1, 8 cycles of alternating polarity → odd grants alternate ring, PE, ring, PE (ring first after reset); never simultaneous. Under RING_PRIORITY_EN: ring every grant.
- ro=0 with full_even=1 for 3 even-external phases → so=0, dout=0, no even grants. Set ro=1 → so=1 with the original data; grant resumes at the following even internal phase.
- req_pe_even=1 while polarity=1 → no even grant. Odd VC grants independently in the same cycle.
- rst asserted the cycle after a capture, before the send → so never asserts for that packet. After rst drops, a held request is regranted with the ring preferred.
- Both VCs driven concurrently: even from ring, odd from PE, ro=1, polarity toggling → steady output alternates even and odd packets, one per cycle, no data corruption (compare against scoreboard).

Source files
------------

// File: rtl/ring_out_arbiter_if.sv
// Handshake/bus bundle between an output-port arbiter and its requesters/downstream link.
// The master side drives requests, packets, phase and downstream ready; the slave side is the arbiter.
interface ring_out_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  polarity;
    logic                  req_ring_even;
    logic                  req_ring_odd;
    logic                  req_pe_even;
    logic                  req_pe_odd;
    logic [DATA_WIDTH-1:0] data_ring_even;
    logic [DATA_WIDTH-1:0] data_ring_odd;
    logic [DATA_WIDTH-1:0] data_pe_even;
    logic [DATA_WIDTH-1:0] data_pe_odd;
    logic                  grant_ring_even;
    logic                  grant_ring_odd;
    logic                  grant_pe_even;
    logic                  grant_pe_odd;
    logic                  ro;
    logic                  so;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output polarity,
        output req_ring_even, req_ring_odd, req_pe_even, req_pe_odd,
        output data_ring_even, data_ring_odd, data_pe_even, data_pe_odd,
        output ro,
        input  grant_ring_even, grant_ring_odd, grant_pe_even, grant_pe_odd,
        input  so, dout
    );

    modport slave (
        input  polarity,
        input  req_ring_even, req_ring_odd, req_pe_even, req_pe_odd,
        input  data_ring_even, data_ring_odd, data_pe_even, data_pe_odd,
        input  ro,
        output grant_ring_even, grant_ring_odd, grant_pe_even, grant_pe_odd,
        output so, dout
    );
endinterface

// File: rtl/ring_out_arbiter.sv
// Ring output-port arbiter: two single-slot VC buffers filled in their internal phase, drained in their external phase.
// Optional macro RING_PRIORITY_EN: ring input always wins contention instead of per-VC round-robin.
module ring_out_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                rst,
    ring_out_arbiter_if.slave  io_bus
);

    logic [DATA_WIDTH-1:0] r_buf_even;
    logic [DATA_WIDTH-1:0] r_buf_odd;
    logic                  r_full_even;
    logic                  r_full_odd;

    logic                  w_pe_pref_even;
    logic                  w_pe_pref_odd;
    logic [1:0]            w_grant_even;   // {ring, pe}
    logic [1:0]            w_grant_odd;    // {ring, pe}
    logic                  w_ve_full;
    logic                  w_so;
    logic [DATA_WIDTH-1:0] w_dout;

    // Picks one requester of a VC; pe_pref breaks a tie in favour of the PE.
    function automatic logic [1:0] f_arbitrate(
        input logic req_ring,
        input logic req_pe,
        input logic pe_pref
    );
        logic [1:0] grant;
        grant = 2'b00;
        if (req_ring && req_pe) begin
            grant = pe_pref ? 2'b01 : 2'b10;
        end else if (req_ring) begin
            grant = 2'b10;
        end else if (req_pe) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
        return grant;
    endfunction

`ifdef RING_PRIORITY_EN
    assign w_pe_pref_even = 1'b0;
    assign w_pe_pref_odd  = 1'b0;
`else
    logic r_rr_even;
    logic r_rr_odd;

    assign w_pe_pref_even = r_rr_even;
    assign w_pe_pref_odd  = r_rr_odd;

    // Round-robin pointer flips toward the loser only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_even <= 1'b0;
            r_rr_odd  <= 1'b0;
        end else begin
            if (w_grant_even[1]) begin
                r_rr_even <= 1'b1;
            end else if (w_grant_even[0]) begin
                r_rr_even <= 1'b0;
            end else begin
                r_rr_even <= r_rr_even;
            end
            if (w_grant_odd[1]) begin
                r_rr_odd <= 1'b1;
            end else if (w_grant_odd[0]) begin
                r_rr_odd <= 1'b0;
            end else begin
                r_rr_odd <= r_rr_odd;
            end
        end
    end
`endif

    // Only the internal VC may grant, and only into an empty buffer.
    always_comb begin
        w_grant_even = 2'b00;
        w_grant_odd  = 2'b00;
        if (rst) begin
            w_grant_even = 2'b00;
            w_grant_odd  = 2'b00;
        end else if (io_bus.polarity) begin
            if (!r_full_odd) begin
                w_grant_odd = f_arbitrate(io_bus.req_ring_odd, io_bus.req_pe_odd, w_pe_pref_odd);
            end else begin
                w_grant_odd = 2'b00;
            end
        end else begin
            if (!r_full_even) begin
                w_grant_even = f_arbitrate(io_bus.req_ring_even, io_bus.req_pe_even, w_pe_pref_even);
            end else begin
                w_grant_even = 2'b00;
            end
        end
    end

    // The external VC is even when polarity=1, odd otherwise.
    assign w_ve_full = io_bus.polarity ? r_full_even : r_full_odd;
    assign w_so      = ~rst & io_bus.ro & w_ve_full;
    assign w_dout    = w_so ? (io_bus.polarity ? r_buf_even : r_buf_odd) : {DATA_WIDTH{1'b0}};

    // Buffer fill on grant, release on accepted send; the two never coincide for one VC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_even  <= {DATA_WIDTH{1'b0}};
            r_buf_odd   <= {DATA_WIDTH{1'b0}};
            r_full_even <= 1'b0;
            r_full_odd  <= 1'b0;
        end else begin
            if (w_grant_even[1]) begin
                r_buf_even  <= io_bus.data_ring_even;
                r_full_even <= 1'b1;
            end else if (w_grant_even[0]) begin
                r_buf_even  <= io_bus.data_pe_even;
                r_full_even <= 1'b1;
            end else if (w_so && io_bus.polarity) begin
                r_full_even <= 1'b0;
            end else begin
                r_full_even <= r_full_even;
            end

            if (w_grant_odd[1]) begin
                r_buf_odd  <= io_bus.data_ring_odd;
                r_full_odd <= 1'b1;
            end else if (w_grant_odd[0]) begin
                r_buf_odd  <= io_bus.data_pe_odd;
                r_full_odd <= 1'b1;
            end else if (w_so && !io_bus.polarity) begin
                r_full_odd <= 1'b0;
            end else begin
                r_full_odd <= r_full_odd;
            end
        end
    end

    assign io_bus.grant_ring_even = w_grant_even[1];
    assign io_bus.grant_pe_even   = w_grant_even[0];
    assign io_bus.grant_ring_odd  = w_grant_odd[1];
    assign io_bus.grant_pe_odd    = w_grant_odd[0];
    assign io_bus.so              = w_so;
    assign io_bus.dout            = w_dout;

endmodule

// File: tb/tb_ring_out_arbiter.sv
// Directed self-checking bench for ring_out_arbiter: grants, send handshake, back-pressure and reset.
module tb_ring_out_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ring_out_arbiter_if #(.DATA_WIDTH(64)) bus ();

    ring_out_arbiter #(.DATA_WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and step just past the edge before driving new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] grants();
        return {60'h0, bus.grant_ring_even, bus.grant_pe_even, bus.grant_ring_odd, bus.grant_pe_odd};
    endfunction

    initial begin
        logic [63:0] exp_d;
        logic [63:0] exp_g;
        logic        ring_wins;
        logic [63:0] q[$];

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.polarity = 1'b1;
        bus.req_ring_even = 1'b0; bus.req_ring_odd = 1'b0;
        bus.req_pe_even = 1'b0;   bus.req_pe_odd = 1'b0;
        bus.data_ring_even = 64'h0; bus.data_ring_odd = 64'h0;
        bus.data_pe_even = 64'h0;   bus.data_pe_odd = 64'h0;
        bus.ro = 1'b1;

        // Reset: grants, so and dout forced low even with a request pending
        tick();
        bus.req_pe_odd = 1'b1;
        tick();
        #1;
        chk("rst_grants", grants(), 64'h0);
        chk("rst_so", {63'h0, bus.so}, 64'h0);
        chk("rst_dout", bus.dout, 64'h0);

        // Single PE odd packet: grant, send next cycle, buffer freed after
        rst = 1'b0;
        bus.polarity = 1'b1;
        bus.data_pe_odd = 64'h4000_0000_0000_00AA;
        #1;
        chk("t1_grant", grants(), 64'h1);
        chk("t1_so_idle", {63'h0, bus.so}, 64'h0);
        tick();
        bus.req_pe_odd = 1'b0;
        bus.polarity = 1'b0;
        #1;
        chk("t1_so", {63'h0, bus.so}, 64'h1);
        chk("t1_dout", bus.dout, 64'h4000_0000_0000_00AA);
        tick();
        bus.polarity = 1'b1;
        tick();
        bus.polarity = 1'b0;
        #1;
        chk("t1_freed", {63'h0, bus.so}, 64'h0);
        tick();

        // Both odd requesters held: alternating grants, ring first
        bus.req_ring_odd = 1'b1;
        bus.req_pe_odd = 1'b1;
        exp_d = 64'h0;
        for (int i = 0; i < 8; i++) begin
            bus.polarity = (i % 2 == 0);
            if (bus.polarity) begin
                bus.data_ring_odd = 64'h1000 + 64'(i);
                bus.data_pe_odd   = 64'h2000 + 64'(i);
`ifdef RING_PRIORITY_EN
                ring_wins = 1'b1;
`else
                ring_wins = ((i / 2) % 2 == 0);
`endif
                exp_g = ring_wins ? 64'h2 : 64'h1;
                exp_d = ring_wins ? bus.data_ring_odd : bus.data_pe_odd;
                #1;
                chk($sformatf("t2_grant_%0d", i), grants(), exp_g);
                chk($sformatf("t2_so_idle_%0d", i), {63'h0, bus.so}, 64'h0);
            end else begin
                #1;
                chk($sformatf("t2_nogrant_%0d", i), grants(), 64'h0);
                chk($sformatf("t2_so_%0d", i), {63'h0, bus.so}, 64'h1);
                chk($sformatf("t2_dout_%0d", i), bus.dout, exp_d);
            end
            tick();
        end
        bus.req_ring_odd = 1'b0;
        bus.req_pe_odd = 1'b0;

        // Even buffer blocked by ro=0 for three external phases
        bus.polarity = 1'b0;
        bus.ro = 1'b0;
        bus.req_ring_even = 1'b1;
        bus.data_ring_even = 64'hE1E1_0000_0000_0001;
        #1;
        chk("t3_fill", grants(), 64'h8);
        tick();
        bus.req_ring_even = 1'b0;
        bus.req_pe_even = 1'b1;
        bus.data_pe_even = 64'hE2E2_0000_0000_0002;
        for (int k = 0; k < 3; k++) begin
            bus.polarity = 1'b1;
            #1;
            chk($sformatf("t3_hold_so_%0d", k), {63'h0, bus.so}, 64'h0);
            chk($sformatf("t3_hold_dout_%0d", k), bus.dout, 64'h0);
            tick();
            bus.polarity = 1'b0;
            #1;
            chk($sformatf("t3_nogrant_%0d", k), grants(), 64'h0);
            tick();
        end
        bus.polarity = 1'b1;
        bus.ro = 1'b1;
        #1;
        chk("t3_so", {63'h0, bus.so}, 64'h1);
        chk("t3_dout", bus.dout, 64'hE1E1_0000_0000_0001);
        tick();
        bus.polarity = 1'b0;
        #1;
        chk("t3_resume", grants(), 64'h4);
        tick();
        bus.req_pe_even = 1'b0;
        bus.polarity = 1'b1;
        #1;
        chk("t3_dout2", bus.dout, 64'hE2E2_0000_0000_0002);
        tick();

        // Even request during odd-internal phase: only odd grants
        bus.polarity = 1'b1;
        bus.req_pe_even = 1'b1;
        bus.data_pe_even = 64'h0E0E_0000_0000_0044;
        bus.req_ring_odd = 1'b1;
        bus.data_ring_odd = 64'h0D0D_0000_0000_0033;
        #1;
        chk("t4_odd_only", grants(), 64'h2);
        tick();
        bus.req_ring_odd = 1'b0;
        bus.polarity = 1'b0;
        #1;
        chk("t4_even_grant", grants(), 64'h4);
        chk("t4_dout_odd", bus.dout, 64'h0D0D_0000_0000_0033);
        tick();
        bus.req_pe_even = 1'b0;
        bus.polarity = 1'b1;
        #1;
        chk("t4_dout_even", bus.dout, 64'h0E0E_0000_0000_0044);
        tick();

        // Reset between capture and send discards the packet
        bus.polarity = 1'b1;
        bus.req_ring_odd = 1'b1;
        bus.req_pe_odd = 1'b1;
        bus.data_ring_odd = 64'h5555_0000_0000_0001;
        bus.data_pe_odd = 64'h6666_0000_0000_0002;
        #1;
`ifdef RING_PRIORITY_EN
        chk("t5_pre_grant", grants(), 64'h2);
`else
        chk("t5_pre_grant", grants(), 64'h1);
`endif
        tick();
        rst = 1'b1;
        bus.polarity = 1'b0;
        #1;
        chk("t5_rst_so", {63'h0, bus.so}, 64'h0);
        chk("t5_rst_grants", grants(), 64'h0);
        tick();
        rst = 1'b0;
        bus.polarity = 1'b1;
        #1;
        chk("t5_regrant", grants(), 64'h2);
        tick();
        bus.req_ring_odd = 1'b0;
        bus.req_pe_odd = 1'b0;
        bus.polarity = 1'b0;
        #1;
        chk("t5_dout", bus.dout, 64'h5555_0000_0000_0001);
        tick();

        // Both VCs streaming: even from ring, odd from PE
        bus.req_ring_even = 1'b1;
        bus.req_pe_odd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.polarity = (i % 2 == 1);
            bus.data_ring_even = 64'hE000 + 64'(i);
            bus.data_pe_odd = 64'h0D00 + 64'(i);
            #1;
            chk($sformatf("t6_grant_%0d", i), grants(), bus.polarity ? 64'h1 : 64'h8);
            if (i == 0) begin
                chk("t6_so_0", {63'h0, bus.so}, 64'h0);
            end else begin
                exp_d = q.pop_front();
                chk($sformatf("t6_so_%0d", i), {63'h0, bus.so}, 64'h1);
                chk($sformatf("t6_dout_%0d", i), bus.dout, exp_d);
            end
            q.push_back(bus.polarity ? bus.data_pe_odd : bus.data_ring_even);
            tick();
        end
        bus.req_ring_even = 1'b0;
        bus.req_pe_odd = 1'b0;
        bus.polarity = 1'b0;
        #1;
        exp_d = q.pop_front();
        chk("t6_so_last", {63'h0, bus.so}, 64'h1);
        chk("t6_dout_last", bus.dout, exp_d);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
